// File: rtl/sram_multibank_wrapper.sv
// sram_multibank_wrapper
//   Word-addressed SRAM built from NUM_BANKS side-by-side banks with per-bank
//   write enables. Reads travel through an RD_LAT-stage pipeline into a
//   fall-through output buffer of RD_LAT+1 entries, which gives rd_ready
//   backpressure. Out-of-range requests raise a registered addr_err pulse and
//   bump a saturating 8-bit error counter.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_mem_en         global enable for new requests
//   i_rd_req/i_wr_req read / write strobes (write wins when both are high)
//   i_address        word address
//   i_wr_data/i_wr_be write data and per-bank write enable
//   o_req_ready      a read would be accepted this cycle
//   o_rd_data        read data, valid when o_rd_data_val
//   o_rd_data_val    read data valid
//   i_rd_ready       consumer takes o_rd_data this cycle
//   o_addr_err       one-cycle pulse after an out-of-range acceptance
//   o_err_cnt        saturating count of o_addr_err pulses
module sram_multibank_wrapper #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_BANKS = 2,
   parameter int unsigned DEPTH     = 100,
   parameter int unsigned RD_LAT    = 1,
   localparam int unsigned ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_mem_en,
   input  logic                 i_rd_req,
   input  logic                 i_wr_req,
   input  logic [ADDR_W-1:0]    i_address,
   input  logic [DATA_W-1:0]    i_wr_data,
   input  logic [NUM_BANKS-1:0] i_wr_be,
   output logic                 o_req_ready,
   output logic [DATA_W-1:0]    o_rd_data,
   output logic                 o_rd_data_val,
   input  logic                 i_rd_ready,
   output logic                 o_addr_err,
   output logic [7:0]           o_err_cnt
);

   localparam int unsigned BANK_W = DATA_W / NUM_BANKS;
   localparam int unsigned FD     = RD_LAT + 1;
   localparam int unsigned PTR_W  = $clog2(FD);

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [RD_LAT-1:0] r_pipe_val;
   logic [DATA_W-1:0] r_pipe_data [RD_LAT];

   logic [DATA_W-1:0] r_fifo [FD];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   // Occupancy never exceeds 2*RD_LAT+1 <= 7, so 4 bits is enough.
   logic [3:0]        r_fifo_cnt;

   logic              r_addr_err;
   logic [7:0]        r_err_cnt;

   logic              w_in_range;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_err;
   logic [3:0]        w_inflight;
   logic [DATA_W-1:0] w_rd_word;
   logic              w_last_val;
   logic [DATA_W-1:0] w_last_data;
   logic              w_fifo_empty;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;

   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == FD - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      w_inflight = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         w_inflight = w_inflight + {3'b000, r_pipe_val[i]};
      end
   end

   // Registered state only: no path from the request strobes.
   assign o_req_ready = (w_inflight + r_fifo_cnt) < 4'(FD);

   assign w_in_range = 32'(i_address) < DEPTH;
   assign w_wr_acc   = i_mem_en & i_wr_req;
   assign w_rd_acc   = i_mem_en & i_rd_req & ~i_wr_req & o_req_ready;
   assign w_err      = (w_wr_acc | w_rd_acc) & ~w_in_range;
   assign w_rd_word  = w_in_range ? r_mem[i_address] : '0;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc && w_in_range) begin
         for (int unsigned k = 0; k < NUM_BANKS; k++) begin
            if (i_wr_be[k]) begin
               r_mem[i_address][k*BANK_W +: BANK_W] <= i_wr_data[k*BANK_W +: BANK_W];
            end
         end
      end
   end

   // Read pipeline always advances; capacity is guaranteed by o_req_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe_val <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_pipe_data[i] <= '0;
         end
      end else begin
         r_pipe_val[0]  <= w_rd_acc;
         r_pipe_data[0] <= w_rd_word;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_pipe_val[i]  <= r_pipe_val[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
         end
      end
   end

   assign w_last_val   = r_pipe_val[RD_LAT-1];
   assign w_last_data  = r_pipe_data[RD_LAT-1];
   assign w_fifo_empty = (r_fifo_cnt == 4'd0);
   // Fall-through: an empty buffer shows the last pipeline stage directly,
   // so a read arrives RD_LAT cycles after acceptance.
   assign w_bypass     = w_fifo_empty & w_last_val & i_rd_ready;
   assign w_push       = w_last_val & ~w_bypass;
   assign w_pop        = ~w_fifo_empty & i_rd_ready;

   assign o_rd_data_val = ~w_fifo_empty | w_last_val;
   assign o_rd_data     = !w_fifo_empty ? r_fifo[r_rd_ptr] :
                          (w_last_val ? w_last_data : '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= w_last_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
         r_fifo_cnt <= r_fifo_cnt + {3'b000, w_push} - {3'b000, w_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_err <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         r_addr_err <= w_err;
         if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign o_addr_err = r_addr_err;
   assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_sram_multibank_wrapper.sv
module tb_sram_multibank_wrapper;

   logic        clk;
   logic        rst_n;
   logic        mem_en;
   logic        rd_req;
   logic        wr_req;
   logic [6:0]  address;
   logic [31:0] wr_data;
   logic [1:0]  wr_be;
   logic        rd_ready;

   logic        l1_ready, l1_val, l1_err;
   logic [31:0] l1_data;
   logic [7:0]  l1_cnt;
   logic        l2_ready, l2_val, l2_err;
   logic [31:0] l2_data;
   logic [7:0]  l2_cnt;

   int total;
   int bad;

   sram_multibank_wrapper #(.DATA_W(32), .NUM_BANKS(2), .DEPTH(100), .RD_LAT(1)) u_l1 (
      .clk(clk), .rst_n(rst_n), .i_mem_en(mem_en), .i_rd_req(rd_req), .i_wr_req(wr_req),
      .i_address(address), .i_wr_data(wr_data), .i_wr_be(wr_be), .o_req_ready(l1_ready),
      .o_rd_data(l1_data), .o_rd_data_val(l1_val), .i_rd_ready(rd_ready),
      .o_addr_err(l1_err), .o_err_cnt(l1_cnt)
   );

   sram_multibank_wrapper #(.DATA_W(32), .NUM_BANKS(2), .DEPTH(100), .RD_LAT(2)) u_l2 (
      .clk(clk), .rst_n(rst_n), .i_mem_en(mem_en), .i_rd_req(rd_req), .i_wr_req(wr_req),
      .i_address(address), .i_wr_data(wr_data), .i_wr_be(wr_be), .o_req_ready(l2_ready),
      .o_rd_data(l2_data), .o_rd_data_val(l2_val), .i_rd_ready(rd_ready),
      .o_addr_err(l2_err), .o_err_cnt(l2_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rd;
      logic        wr;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [1:0]  be;
      logic        val;
      logic [31:0] data;
      logic        err;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic en, input logic rd, input logic wr,
                               input logic [6:0] a, input logic [31:0] wd,
                               input logic [1:0] be, input logic val,
                               input logic [31:0] d, input logic err,
                               input logic [7:0] cnt);
      vec_t v;
      v.en = en; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.be = be;
      v.val = val; v.data = d; v.err = err; v.cnt = cnt;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic rd, input logic wr, input logic [6:0] a,
                        input logic [31:0] wd, input logic [1:0] be);
      mem_en = en; rd_req = rd; wr_req = wr; address = a; wr_data = wd; wr_be = be;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 7'd0, 32'h0, 2'b00);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      rd_ready = 1'b1;
      idle();

      // Expectations refer to the RD_LAT=2 instance, sampled one cycle after
      // the row's inputs were applied.
      tbl[0]  = mk(1'b1, 1'b0, 1'b1, 7'd5,   32'hDEADBEEF, 2'b11, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 7'd5,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[2]  = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b1, 32'hDEADBEEF, 1'b0, 8'd0);
      tbl[3]  = mk(1'b1, 1'b0, 1'b1, 7'd7,   32'h11112222, 2'b11, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[4]  = mk(1'b1, 1'b0, 1'b1, 7'd7,   32'hAAAABBBB, 2'b01, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[5]  = mk(1'b1, 1'b1, 1'b0, 7'd7,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b1, 32'h1111BBBB, 1'b0, 8'd0);
      tbl[7]  = mk(1'b1, 1'b1, 1'b1, 7'd3,   32'h33334444, 2'b11, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[8]  = mk(1'b1, 1'b1, 1'b0, 7'd3,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd0);
      tbl[9]  = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b1, 32'h33334444, 1'b0, 8'd0);
      tbl[10] = mk(1'b1, 1'b1, 1'b0, 7'd100, 32'h0,        2'b00, 1'b0, 32'h0,        1'b1, 8'd1);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b1, 32'h0,        1'b0, 8'd1);
      tbl[12] = mk(1'b1, 1'b0, 1'b1, 7'd100, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1, 8'd2);
      tbl[13] = mk(1'b0, 1'b0, 1'b1, 7'd5,   32'h00000000, 2'b11, 1'b0, 32'h0,        1'b0, 8'd2);
      tbl[14] = mk(1'b0, 1'b1, 1'b0, 7'd5,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd2);
      tbl[15] = mk(1'b1, 1'b1, 1'b0, 7'd5,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd2);
      tbl[16] = mk(1'b1, 1'b1, 1'b0, 7'd7,   32'h0,        2'b00, 1'b1, 32'hDEADBEEF, 1'b0, 8'd2);
      tbl[17] = mk(1'b1, 1'b1, 1'b0, 7'd3,   32'h0,        2'b00, 1'b1, 32'h1111BBBB, 1'b0, 8'd2);
      tbl[18] = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b1, 32'h33334444, 1'b0, 8'd2);
      tbl[19] = mk(1'b0, 1'b0, 1'b0, 7'd0,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 8'd2);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst l1 ready", 32'(l1_ready), 32'd1);
      check("rst l2 ready", 32'(l2_ready), 32'd1);
      check("rst l2 val",   32'(l2_val),   32'd0);
      check("rst l2 data",  l2_data,       32'h0);
      check("rst l2 err",   32'(l2_err),   32'd0);
      check("rst l2 cnt",   32'(l2_cnt),   32'd0);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].en, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be);
         @(negedge clk);
         check($sformatf("row%0d val", i), 32'(l2_val), 32'(tbl[i].val));
         if (tbl[i].val) check($sformatf("row%0d data", i), l2_data, tbl[i].data);
         check($sformatf("row%0d err", i), 32'(l2_err), 32'(tbl[i].err));
         check($sformatf("row%0d cnt", i), 32'(l2_cnt), 32'(tbl[i].cnt));
      end

      // Backpressure: RD_LAT=1 takes exactly two, RD_LAT=2 takes three.
      rd_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 7'd5, 32'h0, 2'b00);
      @(negedge clk);
      check("bp l1 ready1", 32'(l1_ready), 32'd1);
      check("bp l1 data1",  l1_data,       32'hDEADBEEF);
      address = 7'd7;
      @(negedge clk);
      check("bp l1 ready2", 32'(l1_ready), 32'd0);
      check("bp l1 val2",   32'(l1_val),   32'd1);
      check("bp l2 val2",   32'(l2_val),   32'd1);
      address = 7'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bp hold%0d l1 ready", i), 32'(l1_ready), 32'd0);
         check($sformatf("bp hold%0d l1 data", i),  l1_data,       32'hDEADBEEF);
         check($sformatf("bp hold%0d l2 data", i),  l2_data,       32'hDEADBEEF);
      end
      check("bp l2 ready", 32'(l2_ready), 32'd0);
      idle();
      rd_ready = 1'b1;
      @(negedge clk);
      check("drain1 l1 val",  32'(l1_val), 32'd1);
      check("drain1 l1 data", l1_data,     32'h1111BBBB);
      check("drain1 l2 data", l2_data,     32'h1111BBBB);
      @(negedge clk);
      check("drain2 l1 val",   32'(l1_val),   32'd0);
      check("drain2 l1 ready", 32'(l1_ready), 32'd1);
      check("drain2 l2 data",  l2_data,       32'h33334444);
      @(negedge clk);
      check("drain3 l2 val",   32'(l2_val),   32'd0);
      check("drain3 l2 ready", 32'(l2_ready), 32'd1);

      // Reset with two reads in flight.
      drive(1'b1, 1'b1, 1'b0, 7'd5, 32'h0, 2'b00);
      @(negedge clk);
      address = 7'd7;
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      #1;
      check("inrst l2 val",  32'(l2_val), 32'd0);
      check("inrst l2 data", l2_data,     32'h0);
      check("inrst l1 val",  32'(l1_val), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("postrst%0d l2 val", i),   32'(l2_val),   32'd0);
         check($sformatf("postrst%0d l1 val", i),   32'(l1_val),   32'd0);
         check($sformatf("postrst%0d l2 ready", i), 32'(l2_ready), 32'd1);
      end

      // Out-of-range read, then saturation of the error counter.
      drive(1'b1, 1'b1, 1'b0, 7'd100, 32'h0, 2'b00);
      @(negedge clk);
      check("oor l1 err",  32'(l1_err), 32'd1);
      check("oor l1 cnt",  32'(l1_cnt), 32'd1);
      check("oor l1 val",  32'(l1_val), 32'd1);
      check("oor l1 data", l1_data,     32'h0);
      idle();
      @(negedge clk);
      check("oor l1 err off", 32'(l1_err), 32'd0);
      check("oor l2 cnt",     32'(l2_cnt), 32'd1);
      check("oor l2 val",     32'(l2_val), 32'd1);
      check("oor l2 data",    l2_data,     32'h0);
      drive(1'b1, 1'b1, 1'b0, 7'd100, 32'h0, 2'b00);
      repeat (299) @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      check("sat l1 cnt", 32'(l1_cnt), 32'd255);
      check("sat l2 cnt", 32'(l2_cnt), 32'd255);
      check("sat l2 err", 32'(l2_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_multibank_wrapper.md
SRAM_MULTIBANK_WRAPPER -- requirements
Module: sram_multibank_wrapper

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning total word width across all banks; DATA_W SHALL be an integer multiple of NUM_BANKS.
REQ-002 The block SHALL have parameter NUM_BANKS, default 2, meaning number of side-by-side memory banks, each BANK_W = DATA_W/NUM_BANKS bits wide.
REQ-003 The block SHALL have parameter DEPTH, default 100, meaning number of words; ADDR_W = $clog2(DEPTH) is derived and not user-set.
REQ-004 The block SHALL have parameter RD_LAT, default 1, legal range 1..3, meaning read latency in cycles from read acceptance to rd_data_val.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 mem_en  input  1  global enable; requests are ignored while low.
REQ-008 rd_req / wr_req  input  1 each  read and write request strobes.
REQ-009 address  input  ADDR_W  word address for the current request.
REQ-010 wr_data  input  DATA_W  write data; bank k uses bits [(k+1)*BANK_W-1 : k*BANK_W].
REQ-011 wr_be  input  NUM_BANKS  per-bank write enable; bit k gates bank k.
REQ-012 req_ready  output  1  high when a read would be accepted this cycle.
REQ-013 rd_data  output  DATA_W  read data, bank NUM_BANKS-1 in the MSBs.
REQ-014 rd_data_val  output  1  rd_data holds valid data.
REQ-015 rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-016 addr_err  output  1  one-cycle pulse on any accepted request with address >= DEPTH.
REQ-017 err_cnt  output  8  saturating count of addr_err pulses.

Function
REQ-018 A write SHALL be accepted whenever mem_en & wr_req, independent of req_ready, and completes in that cycle.
REQ-019 A read SHALL be accepted only when mem_en & rd_req & ~wr_req & req_ready; when rd_req and wr_req are both high, the write wins and the read is not accepted, so the requester must hold rd_req.
REQ-020 On an accepted write, bank k SHALL be updated only where wr_be[k] = 1; banks with wr_be[k] = 0 keep their contents.
REQ-021 Accepted reads SHALL flow through an RD_LAT-stage pipeline into an output buffer of RD_LAT+1 entries, returning data in acceptance order.
REQ-022 req_ready SHALL equal (in-flight reads + buffered entries) < RD_LAT+1, computed from registered state only, with no combinational path from rd_req or wr_req.
REQ-023 With rd_ready held high, rd_data_val SHALL assert exactly RD_LAT cycles after acceptance, sustaining one read per cycle.
REQ-024 While rd_data_val = 1 and rd_ready = 0, rd_data and rd_data_val SHALL remain stable; an entry is popped only when rd_data_val & rd_ready.
REQ-025 A read accepted in the cycle after a write to the same address SHALL return the newly written data, including the wr_be merge.
REQ-026 An accepted write with address >= DEPTH SHALL be dropped without modifying memory.
REQ-027 An accepted read with address >= DEPTH SHALL still occupy a slot and return all-zero data.
REQ-028 addr_err SHALL pulse for one cycle, registered, in the cycle after an out-of-range acceptance.
REQ-029 err_cnt SHALL increment on each addr_err pulse and saturate at 255.
REQ-030 Deasserting mem_en SHALL block new acceptances while in-flight reads continue to drain to the output buffer.

Reset
REQ-031 While rst_n = 0: rd_data_val = 0, rd_data = 0, addr_err = 0, err_cnt = 0, all in-flight reads and buffered entries are discarded, and req_ready = 1 from the first cycle after release.
REQ-032 Memory contents SHALL NOT be reset and are undefined until written.

Verification
REQ-033 RD_LAT=2: write 0xDEADBEEF to address 5 with wr_be=2'b11, then read address 5 -> rd_data_val high 2 cycles after acceptance with rd_data = 0xDEADBEEF.
REQ-034 Partial write: address 7 holds 0x11112222, then write 0xAAAABBBB with wr_be=2'b01 -> a read of address 7 returns 0x1111BBBB.
REQ-035 Backpressure, RD_LAT=1: rd_ready=0 while issuing back-to-back reads -> exactly 2 accepted, then req_ready=0; rd_data stays stable; raising rd_ready returns both entries in order.
REQ-036 Simultaneous rd_req=1 and wr_req=1 to address 3 -> write performed, no read accepted that cycle; rd_req held next cycle -> read returns the written data.
REQ-037 Read address 100 with DEPTH=100 -> rd_data = 0, addr_err pulses once, err_cnt = 1; 300 such errors -> err_cnt = 255.
REQ-038 Assert rst_n=0 with 2 reads in flight -> no rd_data_val after release and req_ready = 1.
